// File: rtl/arm_pose_sequencer.sv
// Pick-up script sequencer feeding the arm servo PWM controller's select/target inputs.
// Define ARM_SEQ_HOME_EN to append three home-pose steps (indices 6..8) to the script.
module arm_pose_sequencer #(
    parameter int DWELL_CYCLES = 25000000,
    parameter int HOME_ANGLE   = 90
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       START,
    input  logic       ABORT,
    output logic [4:0] SEL,
    output logic [7:0] ANGLE,
    output logic [3:0] STEP,
    output logic       BUSY,
    output logic       DONE
);

    localparam int CNT_W = $clog2(DWELL_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL_CYCLES - 1);
    localparam logic [7:0] HOME_A = 8'(HOME_ANGLE);

`ifdef ARM_SEQ_HOME_EN
    localparam logic [3:0] LAST_STEP = 4'd8;
`else
    localparam logic [3:0] LAST_STEP = 4'd5;
`endif

    // Elaboration-time sanity check of the configuration.
    if (DWELL_CYCLES < 2 || HOME_ANGLE > 180) begin : g_param_check
        $error("arm_pose_sequencer: DWELL_CYCLES must be >= 2 and HOME_ANGLE <= 180");
    end

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_DWELL = 2'd2
    } state_t;

    state_t           state_r;
    logic [CNT_W-1:0] cnt_r;
    logic [4:0]       sel_r;
    logic [7:0]       angle_r;
    logic [3:0]       step_r;
    logic             busy_r;
    logic             done_r;

    // Script ROM: {joint select, target angle} for each step index.
    function automatic logic [12:0] script_rom(input logic [3:0] idx);
        logic [12:0] entry;
        case (idx)
            4'd0:    entry = {5'd2, 8'd90};
            4'd1:    entry = {5'd1, 8'd45};
            4'd2:    entry = {5'd4, 8'd170};
            4'd3:    entry = {5'd2, 8'd30};
            4'd4:    entry = {5'd4, 8'd20};
            4'd5:    entry = {5'd2, 8'd90};
`ifdef ARM_SEQ_HOME_EN
            4'd6:    entry = {5'd4, HOME_A};
            4'd7:    entry = {5'd1, HOME_A};
            4'd8:    entry = {5'd2, HOME_A};
`endif
            default: entry = {5'd0, 8'd0};
        endcase
        return entry;
    endfunction

    // Sequencer FSM with all outputs registered.
    always_ff @(posedge CLK) begin
        done_r <= 1'b0;
        if (RST) begin
            state_r <= S_IDLE;
            cnt_r   <= '0;
            sel_r   <= 5'd0;
            angle_r <= 8'd0;
            step_r  <= 4'd0;
            busy_r  <= 1'b0;
        end else if (ABORT) begin
            // ANGLE deliberately keeps its last value so the servo holds position.
            state_r <= S_IDLE;
            cnt_r   <= '0;
            sel_r   <= 5'd0;
            step_r  <= 4'd0;
            busy_r  <= 1'b0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (START) begin
                        state_r <= S_LOAD;
                        step_r  <= 4'd0;
                    end
                end
                S_LOAD: begin
                    {sel_r, angle_r} <= script_rom(step_r);
                    busy_r  <= 1'b1;
                    cnt_r   <= '0;
                    state_r <= S_DWELL;
                end
                S_DWELL: begin
                    if (cnt_r == CNT_LAST) begin
                        if (step_r == LAST_STEP) begin
                            done_r  <= 1'b1;
                            busy_r  <= 1'b0;
                            sel_r   <= 5'd0;
                            step_r  <= 4'd0;
                            state_r <= S_IDLE;
                        end else begin
                            step_r  <= step_r + 4'd1;
                            state_r <= S_LOAD;
                        end
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end
                default: begin
                    state_r <= S_IDLE;
                    busy_r  <= 1'b0;
                    sel_r   <= 5'd0;
                end
            endcase
        end
    end

    assign SEL   = sel_r;
    assign ANGLE = angle_r;
    assign STEP  = step_r;
    assign BUSY  = busy_r;
    assign DONE  = done_r;

endmodule

// File: tb/tb_arm_pose_sequencer.sv
// Directed self-checking bench for arm_pose_sequencer (DWELL_CYCLES = 4, HOME_ANGLE = 90).
module tb_arm_pose_sequencer;

    localparam int DW       = 4;
    localparam int STEP_CYC = DW + 1;
`ifdef ARM_SEQ_HOME_EN
    localparam int N_STEPS  = 9;
`else
    localparam int N_STEPS  = 6;
`endif
    localparam int DONE_CYC = 1 + N_STEPS * STEP_CYC;

    logic       CLK = 1'b0;
    logic       RST;
    logic       START;
    logic       ABORT;
    logic [4:0] SEL;
    logic [7:0] ANGLE;
    logic [3:0] STEP;
    logic       BUSY;
    logic       DONE;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [4:0] exp_sel_tab [0:8];
    logic [7:0] exp_ang_tab [0:8];

    always #5 CLK = ~CLK;

    arm_pose_sequencer #(.DWELL_CYCLES(DW), .HOME_ANGLE(90)) dut (
        .CLK   (CLK),
        .RST   (RST),
        .START (START),
        .ABORT (ABORT),
        .SEL   (SEL),
        .ANGLE (ANGLE),
        .STEP  (STEP),
        .BUSY  (BUSY),
        .DONE  (DONE)
    );

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        tests_run++;
        assert (obs === expv) else begin
            tests_failed++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    // Cycle 0 carries the START pulse; kill_c (ABORT or RST) idles the DUT from the next cycle.
    task automatic run_script(input int stray0, input int stray1, input int abort_c,
                              input int rst_c, input int n_cyc);
        logic       killed;
        logic [7:0] held_ang;
        logic [7:0] e_ang;
        logic [4:0] e_sel;
        logic [3:0] e_step;
        logic       e_busy;
        logic       e_done;
        int         s;
        killed   = 1'b0;
        held_ang = 8'd0;
        for (int c = 0; c <= n_cyc; c++) begin
            e_sel  = 5'd0;
            e_ang  = 8'd0;
            e_step = 4'd0;
            e_busy = 1'b0;
            e_done = 1'b0;
            if (!killed) begin
                if (c >= 2 && c < DONE_CYC) begin
                    s      = (c - 2) / STEP_CYC;
                    e_sel  = exp_sel_tab[s];
                    e_ang  = exp_ang_tab[s];
                    e_busy = 1'b1;
                end
                if (c >= 1 && c < DONE_CYC) e_step = 4'((c - 1) / STEP_CYC);
                e_done = (c == DONE_CYC);
            end
            check($sformatf("sel_c%0d", c), 8'(SEL), 8'(e_sel));
            check($sformatf("busy_c%0d", c), 8'(BUSY), 8'(e_busy));
            check($sformatf("done_c%0d", c), 8'(DONE), 8'(e_done));
            check($sformatf("step_c%0d", c), 8'(STEP), 8'(e_step));
            if (killed) check($sformatf("angle_held_c%0d", c), ANGLE, held_ang);
            else if (c >= 2 && c < DONE_CYC) check($sformatf("angle_c%0d", c), ANGLE, e_ang);
            START = (c == 0 || c == stray0 || c == stray1);
            ABORT = (c == abort_c);
            RST   = (c == rst_c);
            if (!killed && (c == abort_c || c == rst_c)) begin
                killed   = 1'b1;
                held_ang = (c == rst_c) ? 8'd0 : e_ang;
            end
            tick();
        end
        START = 1'b0;
        ABORT = 1'b0;
        RST   = 1'b0;
    endtask

    initial begin
        exp_sel_tab = '{5'd2, 5'd1, 5'd4, 5'd2, 5'd4, 5'd2, 5'd4, 5'd1, 5'd2};
        exp_ang_tab = '{8'd90, 8'd45, 8'd170, 8'd30, 8'd20, 8'd90, 8'd90, 8'd90, 8'd90};
        RST   = 1'b1;
        START = 1'b0;
        ABORT = 1'b0;
        repeat (3) tick();
        RST = 1'b0;

        // Reset then idle
        for (int i = 0; i < 10; i++) begin
            check($sformatf("rst_sel_%0d", i), 8'(SEL), 8'd0);
            check($sformatf("rst_angle_%0d", i), ANGLE, 8'd0);
            check($sformatf("rst_busy_%0d", i), 8'(BUSY), 8'd0);
            check($sformatf("rst_done_%0d", i), 8'(DONE), 8'd0);
            check($sformatf("rst_step_%0d", i), 8'(STEP), 8'd0);
            tick();
        end

        // Full script
        run_script(-1, -1, -1, -1, DONE_CYC + 2);
        // START while busy is ignored
        run_script(7, 20, -1, -1, DONE_CYC + 2);
        // ABORT during step 2, then a fresh replay from step 0
        run_script(-1, -1, 13, -1, 20);
        run_script(-1, -1, -1, -1, DONE_CYC + 2);

        // ABORT and START together in IDLE: stays idle
        START = 1'b1;
        ABORT = 1'b1;
        tick();
        START = 1'b0;
        ABORT = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("abst_busy_%0d", i), 8'(BUSY), 8'd0);
            check($sformatf("abst_sel_%0d", i), 8'(SEL), 8'd0);
            check($sformatf("abst_step_%0d", i), 8'(STEP), 8'd0);
            tick();
        end

        // RST on the final terminal-count cycle: reset values, no DONE
        run_script(-1, -1, -1, DONE_CYC - 1, DONE_CYC + 2);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/arm_pose_sequencer.md
# arm_pose_sequencer

- Upstream stage of the arm servo PWM controller.
- On a START request from navigation, plays a fixed pick-up script: one joint select plus one 8-bit target angle per step.
- Holds each step for a programmable dwell so the downstream slew and PWM stage can settle.
- Drives the select/target inputs of the PWM controller in place of the manual buttons and switches.

## Interface
- DWELL_CYCLES, 25000000: clock cycles each step is held (0.25 s at 100 MHz); must be ≥ 2.
- HOME_ANGLE, 90: target angle used by the optional home steps.
- CLK  input  1  system clock; all logic on posedge.
- RST  input  1  synchronous, active-high reset.
- START  input  1  one-cycle request to run the script; honoured only in IDLE.
- ABORT  input  1  level; cancels the script, highest priority after RST.
- SEL  output  5  joint select, button encoding: 5'd4 = claw, 5'd1 = upper joint, 5'd2 = lower joint, 5'd0 = none.
- ANGLE  output  8  target angle for the selected joint, 0–180.
- STEP  output  4  index of the step currently presented.
- BUSY  output  1  high from LOAD through the final DWELL.
- DONE  output  1  one-cycle pulse when the script completes normally.

## Operation
- States:
  - IDLE: SEL = 0, BUSY = 0. START moves to LOAD.
  - LOAD: registers SEL, ANGLE and STEP from script entry STEP; clears the dwell counter. Always moves to DWELL.
  - DWELL: SEL and ANGLE stay constant. Counter runs 0..DWELL_CYCLES-1. On the terminal count, if more steps remain, STEP increments and the FSM goes to LOAD; otherwise DONE pulses and the FSM goes to IDLE.
- Script (fixed combinational ROM, index → SEL, ANGLE):
  - 0 → 2, 90 (lower joint level)
  - 1 → 1, 45 (upper joint forward)
  - 2 → 4, 170 (claw open)
  - 3 → 2, 30 (lower)
  - 4 → 4, 20 (claw close)
  - 5 → 2, 90 (raise)
- Last step index: 5 by default; 8 with ARM_SEQ_HOME_EN.
- START in any state other than IDLE is ignored; no queuing.
- ABORT in any state: next cycle the FSM is in IDLE, SEL = 0, BUSY = 0, STEP = 0, no DONE. ANGLE keeps its last value.
- ABORT and START asserted together in IDLE: ABORT wins and the FSM stays in IDLE.
- ABORT asserted on the same cycle as the final terminal count: ABORT wins and DONE is not pulsed.
- Widths:
  - Dwell counter is $clog2(DWELL_CYCLES) bits; it wraps to 0 only through LOAD.
  - STEP is 4 bits and never exceeds the last index.
  - ANGLE ROM constants are 8 bits; no arithmetic is performed on ANGLE.

## Timing
- Reset values: SEL = 0, ANGLE = 0, STEP = 0, BUSY = 0, DONE = 0, state IDLE, counter 0.
- RST asserted mid-script forces all reset values on the next edge; same effect as ABORT, except ANGLE also returns to 0.
- START sampled at edge N: LOAD occupies cycle N+1. SEL, ANGLE and BUSY are valid from edge N+2, i.e. 2-cycle latency.
- Each step occupies 1 + DWELL_CYCLES cycles.
- Full default script, START edge to DONE high: 1 + 6·(1 + DWELL_CYCLES) cycles.
- DONE is high in the cycle following the final terminal count. BUSY falls on that same edge.
- START is accepted again on the cycle DONE is high, since the FSM is back in IDLE.
- SEL is never 0 while BUSY = 1. Between steps, SEL changes directly from one joint code to the next with no idle gap.

## Configuration
- ARM_SEQ_HOME_EN defined: three steps are appended after step 5:
  - 6 → 4, HOME_ANGLE
  - 7 → 1, HOME_ANGLE
  - 8 → 2, HOME_ANGLE
  - Last index becomes 8; total runtime is 1 + 9·(1 + DWELL_CYCLES).
- Undefined: the script ends at step 5 and home steps are absent from the ROM.

## Test plan
Run with DWELL_CYCLES = 4, HOME_ANGLE = 90.
- Reset then idle: RST high 3 cycles, then low 10 cycles with START = 0 → SEL = 0, ANGLE = 0, BUSY = 0, DONE never high.
- Full script: START pulse at cycle 0, macro undefined →
  - (SEL, ANGLE) sequence is (2,90), (1,45), (4,170), (2,30), (4,20), (2,90), each held 5 cycles, first valid at cycle 2.
  - DONE pulses once at cycle 31; BUSY is low from cycle 31.
- Home script: same stimulus with ARM_SEQ_HOME_EN defined → steps continue with (4,90), (1,90), (2,90); DONE at cycle 46.
- Start while busy: START pulses again at cycles 7 and 20 → no restart; STEP sequence and DONE timing identical to the full-script case.
- Abort mid-step: ABORT high at cycle 13, during step 2 → next cycle SEL = 0, BUSY = 0, STEP = 0, ANGLE = 170; DONE never pulses. A fresh START then replays from step 0.
- Reset vs. final step: RST asserted on the final terminal-count cycle (cycle 30) → all outputs at reset values next cycle; no DONE.
